// File: rtl/hsid_pkg.sv
// Shared widths and loader state encoding for the HSID hyperspectral pixel loader.
package hsid_pkg;

  localparam int HSID_WORD_WIDTH        = 32;
  localparam int HSID_BAND_WIDTH        = HSID_WORD_WIDTH / 2;
  localparam int HSID_HSP_BANDS_WIDTH   = 8;
  localparam int HSID_HSP_LIBRARY_WIDTH = 8;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_CONFIG,
    LD_CAPTURED,
    LD_LIBRARY,
    LD_DONE,
    LD_ERROR,
    LD_CLEAR
  } hsid_loader_state_t;

endpackage

// File: rtl/hsid_hsp_loader_if.sv
// Sample stream in and the two FIFO write ports out of the HSP loader.
interface hsid_hsp_loader_if
  import hsid_pkg::*;
#(
  parameter int WORD_WIDTH = HSID_WORD_WIDTH,
  parameter int BAND_WIDTH = WORD_WIDTH / 2
);
  logic                  sample_valid;
  logic [BAND_WIDTH-1:0] sample_data;
  logic                  sample_ready;

  logic                  fifo_captured_full;
  logic                  fifo_captured_wr_en;
  logic [WORD_WIDTH-1:0] fifo_captured_data;

  logic                  fifo_ref_full;
  logic                  fifo_ref_wr_en;
  logic [WORD_WIDTH-1:0] fifo_ref_data;

  // master: sample source plus FIFO side; slave: the loader itself
  modport master (
    output sample_valid, sample_data, fifo_captured_full, fifo_ref_full,
    input  sample_ready, fifo_captured_wr_en, fifo_captured_data,
           fifo_ref_wr_en, fifo_ref_data
  );

  modport slave (
    input  sample_valid, sample_data, fifo_captured_full, fifo_ref_full,
    output sample_ready, fifo_captured_wr_en, fifo_captured_data,
           fifo_ref_wr_en, fifo_ref_data
  );
endinterface

// File: rtl/hsid_band_packer.sv
// Packs pairs of band samples into one word; a trailing even band is zero-padded.
module hsid_band_packer #(
  parameter int BAND_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    xfer,
  input  logic                    odd,
  input  logic                    last,
  input  logic                    flush,
  input  logic [BAND_WIDTH-1:0]   sample_data,
  output logic                    word_valid,
  output logic [2*BAND_WIDTH-1:0] word
);
  logic [BAND_WIDTH-1:0] low_half;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                low_half <= '0;
    else if (flush)         low_half <= '0;
    else if (xfer && !odd)  low_half <= sample_data;
  end

  always_comb begin
    word_valid = xfer && (odd || last);
    word       = odd ? {sample_data, low_half} : {{BAND_WIDTH{1'b0}}, sample_data};
  end
endmodule

// File: rtl/hsid_hsp_loader.sv
// Loads one captured pixel then a reference library from a band stream into two word FIFOs.
module hsid_hsp_loader
  import hsid_pkg::*;
#(
  parameter int WORD_WIDTH        = HSID_WORD_WIDTH,
  parameter int BAND_WIDTH        = WORD_WIDTH / 2,
  parameter int HSP_BANDS_WIDTH   = HSID_HSP_BANDS_WIDTH,
  parameter int HSP_LIBRARY_WIDTH = HSID_HSP_LIBRARY_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         start,
  input  logic [HSP_BANDS_WIDTH-1:0]   hsp_bands,
  input  logic [HSP_LIBRARY_WIDTH-1:0] hsp_library_size,
  hsid_hsp_loader_if.slave             bus,
  output logic                         idle,
  output logic                         busy,
  output logic                         done,
  output logic                         error,
  output logic                         cancelled
);
  localparam logic [HSP_BANDS_WIDTH-1:0]   BANDS_ONE = HSP_BANDS_WIDTH'(1);
  localparam logic [HSP_LIBRARY_WIDTH-1:0] LIB_ONE   = HSP_LIBRARY_WIDTH'(1);

  hsid_loader_state_t state, next_state;

  logic [HSP_BANDS_WIDTH-1:0]   cfg_hsp_bands, band_count;
  logic [HSP_LIBRARY_WIDTH-1:0] cfg_hsp_library_size, ref_count;
  logic                         ready_int, xfer, last_band, last_ref, cfg_bad, flush;
  logic                         word_valid;
  logic [2*BAND_WIDTH-1:0]      word;

  assign cfg_bad   = (hsp_bands == '0) || (hsp_library_size == '0) || (hsp_bands == BANDS_ONE);
  assign last_band = (band_count == cfg_hsp_bands - BANDS_ONE);
  assign last_ref  = (ref_count == cfg_hsp_library_size - LIB_ONE);
  assign flush     = state inside {LD_DONE, LD_ERROR, LD_CLEAR};

  // clear wins over a pending transfer so nothing is written in the abort cycle
  assign ready_int = !clear &&
                     (((state == LD_CAPTURED) && !bus.fifo_captured_full) ||
                      ((state == LD_LIBRARY)  && !bus.fifo_ref_full));
  assign xfer      = bus.sample_valid && ready_int;

  hsid_band_packer #(.BAND_WIDTH(BAND_WIDTH)) u_packer (
    .clk        (clk),
    .rst        (rst),
    .xfer       (xfer),
    .odd        (band_count[0]),
    .last       (last_band),
    .flush      (flush),
    .sample_data(bus.sample_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LD_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      LD_IDLE:     if (start) next_state = LD_CONFIG;
      LD_CONFIG:   if (clear)        next_state = LD_CLEAR;
                   else if (cfg_bad) next_state = LD_ERROR;
                   else              next_state = LD_CAPTURED;
      LD_CAPTURED: if (clear)                  next_state = LD_CLEAR;
                   else if (xfer && last_band) next_state = LD_LIBRARY;
      LD_LIBRARY:  if (clear)                              next_state = LD_CLEAR;
                   else if (xfer && last_band && last_ref) next_state = LD_DONE;
      default:     next_state = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_hsp_bands        <= '1;
      cfg_hsp_library_size <= '1;
      band_count           <= '0;
      ref_count            <= '0;
    end else if (state == LD_CONFIG) begin
      cfg_hsp_bands        <= hsp_bands;
      cfg_hsp_library_size <= hsp_library_size;
    end else if (flush) begin
      cfg_hsp_bands        <= '1;
      cfg_hsp_library_size <= '1;
      band_count           <= '0;
      ref_count            <= '0;
    end else if (xfer) begin
      band_count <= last_band ? '0 : band_count + BANDS_ONE;
      if ((state == LD_LIBRARY) && last_band)
        ref_count <= last_ref ? '0 : ref_count + LIB_ONE;
    end
  end

  always_comb begin
    bus.sample_ready        = ready_int;
    bus.fifo_captured_wr_en = word_valid && (state == LD_CAPTURED);
    bus.fifo_ref_wr_en      = word_valid && (state == LD_LIBRARY);
    bus.fifo_captured_data  = bus.fifo_captured_wr_en ? WORD_WIDTH'(word) : '0;
    bus.fifo_ref_data       = bus.fifo_ref_wr_en      ? WORD_WIDTH'(word) : '0;
    idle      = (state == LD_IDLE);
    busy      = state inside {LD_CONFIG, LD_CAPTURED, LD_LIBRARY};
    done      = (state == LD_DONE);
    error     = (state == LD_ERROR);
    cancelled = (state == LD_CLEAR);
  end
endmodule

// File: tb/tb_hsid_hsp_loader.sv
// Scoreboard bench for hsid_hsp_loader: a pixel/band model predicts the words each FIFO receives.
module tb_hsid_hsp_loader;
  import hsid_pkg::*;

  logic       clk = 1'b0;
  logic       rst, clear, start;
  logic [7:0] hsp_bands, hsp_library_size;
  logic       idle, busy, done, error, cancelled;

  hsid_hsp_loader_if bus ();

  hsid_hsp_loader dut (
    .clk             (clk),
    .rst             (rst),
    .clear           (clear),
    .start           (start),
    .hsp_bands       (hsp_bands),
    .hsp_library_size(hsp_library_size),
    .bus             (bus),
    .idle            (idle),
    .busy            (busy),
    .done            (done),
    .error           (error),
    .cancelled       (cancelled)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int done_cnt, err_cnt, canc_cnt, ref_wr_total;
  logic [31:0] exp_cap[$];
  logic [31:0] exp_ref[$];
  logic [15:0] src[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Sample i belongs to pixel i/bands, band i%bands; pixel 0 is the captured one.
  task automatic model_push(input int bands, input int n);
    logic [15:0] lo;
    logic [31:0] w;
    int          pix, b;
    lo = '0;
    for (int i = 0; i < n; i++) begin
      pix = i / bands;
      b   = i % bands;
      if (b % 2 == 0) lo = src[i];
      w = (b % 2 == 1) ? {src[i], lo} : {16'h0000, src[i]};
      if ((b % 2 == 1) || (b == bands - 1)) begin
        if (pix == 0) exp_cap.push_back(w);
        else          exp_ref.push_back(w);
      end
    end
  endtask

  always @(negedge clk) begin
    if (bus.fifo_captured_wr_en) begin
      if (exp_cap.size() == 0) begin
        tests++; fails++;
        $display("FAIL cap_unexpected got=%h want=no_write", bus.fifo_captured_data);
      end else check("cap_word", bus.fifo_captured_data, exp_cap.pop_front());
    end
    if (bus.fifo_ref_wr_en) begin
      ref_wr_total++;
      if (exp_ref.size() == 0) begin
        tests++; fails++;
        $display("FAIL ref_unexpected got=%h want=no_write", bus.fifo_ref_data);
      end else check("ref_word", bus.fifo_ref_data, exp_ref.pop_front());
    end
    if (done)      done_cnt++;
    if (error)     err_cnt++;
    if (cancelled) canc_cnt++;
    if ($countones({idle, busy, done, error, cancelled}) != 1) begin
      fails++;
      $display("FAIL status_onehot got=%b want=one_hot", {idle, busy, done, error, cancelled});
    end
    if (bus.sample_ready && (!busy || clear)) begin
      fails++;
      $display("FAIL ready_gating got=1 want=0 (busy=%b clear=%b)", busy, clear);
    end
  end

  task automatic fill_seq(input int n, input int base);
    src.delete();
    for (int i = 0; i < n; i++) src.push_back(16'(base + i));
  endtask

  task automatic fill_rand(input int n);
    src.delete();
    for (int i = 0; i < n; i++) src.push_back(16'($urandom));
  endtask

  task automatic begin_load(input int bands, input int lib);
    done_cnt = 0; err_cnt = 0; canc_cnt = 0; ref_wr_total = 0;
    if (bands > 0) model_push(bands, src.size());
    hsp_bands        = 8'(bands);
    hsp_library_size = 8'(lib);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic drive(input bit stall, input bit hold_ref, input bit poke);
    int  sent, cyc, held;
    bit  fire, holding;
    sent = 0; cyc = 0; held = 0;
    while (sent < src.size() && cyc < 5000) begin
      bus.sample_valid       = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.sample_data        = src[sent];
      bus.fifo_captured_full = stall && ($urandom_range(0, 4) == 0);
      bus.fifo_ref_full      = stall && ($urandom_range(0, 4) == 0);
      holding = hold_ref && (ref_wr_total >= 2) && (held < 5);
      if (holding) begin
        bus.fifo_ref_full = 1'b1;
        held++;
      end
      start = poke && (sent == src.size() / 2);
      @(negedge clk);
      fire = bus.sample_valid && bus.sample_ready;
      if (holding) check("ready_while_ref_full", 32'(bus.sample_ready), 32'd0);
      @(posedge clk); #1;
      if (fire) sent++;
      cyc++;
    end
    bus.sample_valid = 1'b0; bus.fifo_captured_full = 1'b0; bus.fifo_ref_full = 1'b0;
    start = 1'b0;
    if (cyc >= 5000) begin
      tests++; fails++;
      $display("FAIL drive_timeout got=%0d want=%0d samples", sent, src.size());
    end
  endtask

  task automatic finish_load(input int want_done, input int want_err, input int want_canc);
    int cyc;
    cyc = 0;
    while (!idle && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("back_to_idle", 32'(idle), 32'd1);
    check("done_pulses", 32'(done_cnt), 32'(want_done));
    check("error_pulses", 32'(err_cnt), 32'(want_err));
    check("cancel_pulses", 32'(canc_cnt), 32'(want_canc));
    check("cap_queue_left", 32'(exp_cap.size()), 32'd0);
    check("ref_queue_left", 32'(exp_ref.size()), 32'd0);
    exp_cap.delete(); exp_ref.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, l;
    rst = 1'b1; clear = 1'b0; start = 1'b0;
    hsp_bands = '0; hsp_library_size = '0;
    bus.sample_valid = 1'b0; bus.sample_data = '0;
    bus.fifo_captured_full = 1'b0; bus.fifo_ref_full = 1'b0;
    #3;
    check("rst_idle", 32'(idle), 32'd1);
    check("rst_others", 32'({busy, done, error, cancelled, bus.sample_ready,
                            bus.fifo_captured_wr_en, bus.fifo_ref_wr_en}), 32'd0);
    check("rst_data", bus.fifo_captured_data | bus.fifo_ref_data, 32'd0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;

    // 4 bands, 2 reference pixels, samples 1..12, start poked mid-load
    fill_seq(12, 1);
    begin_load(4, 2); drive(1'b0, 1'b0, 1'b1); finish_load(1, 0, 0);

    // 3 bands: trailing band zero-padded
    src.delete();
    src.push_back(16'h00AA); src.push_back(16'h00BB); src.push_back(16'h00CC);
    src.push_back(16'h00DD); src.push_back(16'h00EE); src.push_back(16'h00FF);
    begin_load(3, 1); drive(1'b0, 1'b0, 1'b0); finish_load(1, 0, 0);

    // bad configurations
    src.delete(); begin_load(0, 2); drive(1'b0, 1'b0, 1'b0); finish_load(0, 1, 0);
    src.delete(); begin_load(1, 2); drive(1'b0, 1'b0, 1'b0); finish_load(0, 1, 0);
    src.delete(); begin_load(3, 0); drive(1'b0, 1'b0, 1'b0); finish_load(0, 1, 0);

    // reference FIFO full for 5 cycles after the second reference word
    fill_rand(16);
    begin_load(4, 3); drive(1'b0, 1'b1, 1'b0); finish_load(1, 0, 0);

    // clear after 3 library samples: held half-word must be dropped
    fill_seq(7, 16'h0100);
    begin_load(4, 2); drive(1'b0, 1'b0, 1'b0);
    bus.sample_valid = 1'b1; bus.sample_data = 16'hDEAD;
    clear = 1'b1;
    #1 check("ready_during_clear", 32'(bus.sample_ready), 32'd0);
    @(posedge clk); #1 clear = 1'b0; bus.sample_valid = 1'b0;
    check("cancelled_after_clear", 32'(cancelled), 32'd1);
    finish_load(0, 0, 1);
    fill_seq(12, 16'h0200);
    begin_load(4, 2); drive(1'b0, 1'b0, 1'b0); finish_load(1, 0, 0);

    // asynchronous reset in the middle of the captured pixel
    fill_seq(3, 16'h0300);
    begin_load(4, 2); drive(1'b0, 1'b0, 1'b0);
    bus.sample_valid = 1'b1; bus.sample_data = 16'hBEEF;
    #1 rst = 1'b1;
    #1;
    check("midrst_idle", 32'(idle), 32'd1);
    check("midrst_outputs", 32'({busy, done, error, cancelled, bus.sample_ready,
                                bus.fifo_captured_wr_en, bus.fifo_ref_wr_en}), 32'd0);
    @(posedge clk); #1 rst = 1'b0; bus.sample_valid = 1'b0;
    @(posedge clk); #1;
    finish_load(0, 0, 0);

    // randomized loads with random valid gaps and FIFO back-pressure
    for (int k = 0; k < 8; k++) begin
      b = $urandom_range(2, 7);
      l = $urandom_range(1, 4);
      fill_rand(b * (l + 1));
      begin_load(b, l); drive(1'b1, 1'b0, k[0]); finish_load(1, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
